mmio_bridge: RTL and testbench



---
 rtl/mmio_bridge_pkg.sv | 38 +++
 rtl/mmio_bridge_fifo.sv | 73 +++++++
 rtl/mmio_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_mmio_bridge.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared constants, read-select codes and decode helper for the MMIO bridge.
// Width macros are guarded so an including project may override them.
`ifndef MMIO_BYTE_W
`define MMIO_BYTE_W 8
`endif
`ifndef MMIO_WORD_W
`define MMIO_WORD_W 32
`endif

package mmio_bridge_pkg;

    localparam int BYTE_W = `MMIO_BYTE_W;
    localparam int WORD_W = `MMIO_WORD_W;

    localparam logic [17:0] IO_BASE   = 18'h30000;
    localparam logic [1:0]  IO_REGION = IO_BASE[17:16];

    localparam logic [15:0] OFF_UART = 16'h0000;
    localparam logic [15:0] OFF_CNT  = 16'h0004;
    localparam logic [15:0] OFF_STAT = 16'h0008;

    typedef enum logic [3:0] {
        SEL_RAM,
        SEL_RX,
        SEL_CNT0,
        SEL_CNT1,
        SEL_CNT2,
        SEL_CNT3,
        SEL_STAT0,
        SEL_STAT1,
        SEL_ZERO
    } sel_e;

    function automatic logic is_io_addr(input logic [17:0] addr);
        return addr[17:16] == IO_REGION;
    endfunction

endpackage

// File: rtl/mmio_bridge_fifo.sv
// Small circular byte FIFO with exposed count/next-count; head is read
// combinationally so the consumer sees the oldest byte without extra latency.
module byte_fifo #(
    parameter int DEPTH_LOG = 3,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [DEPTH_LOG:0]   count,
    output logic [DEPTH_LOG:0]   count_next,
    output logic                 full,
    output logic                 empty,
    output logic                 push_drop
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0]   FULL_COUNT = {1'b1, {DEPTH_LOG{1'b0}}};
    localparam logic [DEPTH_LOG:0]   CNT_ONE    = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG-1:0] PTR_ONE    = {{(DEPTH_LOG-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]     mem_reg [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_reg;
    logic [DEPTH_LOG-1:0] rd_ptr_reg;
    logic [DEPTH_LOG:0]   count_reg;
    logic                 push_ok;
    logic                 pop_ok;

    assign full      = (count_reg == FULL_COUNT);
    assign empty     = (count_reg == '0);
    assign pop_ok    = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push_ok   = push & (~full | pop_ok);
    assign push_drop = push & ~push_ok;

    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Splits the CPU byte bus between RAM and I/O: UART TX FIFO, RX path, cycle
// counter snapshot and program-stop flag. Define MMIO_STAT_EN for the drop counter.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int TX_DEPTH_LOG = 3,
    parameter int FULL_MARGIN  = 2,
    parameter int RAM_AW       = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [31:0]       cpu_mem_a,
    input  logic              cpu_mem_wr,
    input  logic [BYTE_W-1:0] cpu_mem_dout,
    output logic [BYTE_W-1:0] cpu_mem_din,
    output logic              io_buffer_full,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_a,
    output logic [BYTE_W-1:0] ram_wdata,
    input  logic [BYTE_W-1:0] ram_rdata,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ack,
    output logic              prog_stop
);

    localparam int FULL_LEVEL = (1 << TX_DEPTH_LOG) - FULL_MARGIN;
    localparam int NUM_BYTES  = WORD_W / BYTE_W;

    logic                  is_io;
    logic [15:0]           io_off;
    logic                  rd_req;
    logic                  wr_io;
    logic                  uart_wr;
    logic                  stop_wr;
    sel_e                  sel_next;
    sel_e                  sel_reg;
    logic                  rd_valid_reg;
    logic [BYTE_W-1:0]     rx_byte_reg;
    logic [WORD_W-1:0]     cnt_reg;
    logic [WORD_W-1:0]     snap_reg;
    logic [BYTE_W-1:0]     snap_bytes [NUM_BYTES];
    logic                  prog_stop_reg;
    logic                  io_full_reg;

    logic                  tx_push;
    logic [BYTE_W-1:0]     tx_push_data;
    logic                  tx_pop;
    logic [TX_DEPTH_LOG:0] tx_count;
    logic [TX_DEPTH_LOG:0] tx_count_next;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_drop;

    logic                  unused_bits;
    assign unused_bits = ^{cpu_mem_a[31:18], tx_full, tx_empty};

    assign is_io  = is_io_addr(cpu_mem_a[17:0]);
    assign io_off = cpu_mem_a[15:0];
    assign rd_req = ~cpu_mem_wr & ~rst_in;
    assign wr_io  = cpu_mem_wr & ~rst_in & is_io;

    assign ram_a     = cpu_mem_a[RAM_AW-1:0];
    assign ram_we    = cpu_mem_wr & ~rst_in & ~is_io;
    assign ram_wdata = cpu_mem_dout;

    // rx_ack is combinational so the UART sees its byte consumed in the read cycle itself.
    assign rx_ack = rd_req & is_io & (io_off == OFF_UART) & rx_valid;

    assign uart_wr      = wr_io & (io_off == OFF_UART);
    assign stop_wr      = wr_io & (io_off == OFF_CNT);
    assign tx_push      = (uart_wr & (cpu_mem_dout != '0)) | stop_wr;
    assign tx_push_data = stop_wr ? '0 : cpu_mem_dout;
    assign tx_valid     = (tx_count != '0);
    assign tx_pop       = tx_valid & tx_ready;

    assign io_buffer_full = io_full_reg;
    assign prog_stop      = prog_stop_reg;

    byte_fifo #(
        .DEPTH_LOG (TX_DEPTH_LOG),
        .WIDTH     (BYTE_W)
    ) u_tx_fifo (
        .clk        (clk_in),
        .srst       (rst_in),
        .push       (tx_push),
        .push_data  (tx_push_data),
        .pop        (tx_pop),
        .head       (tx_data),
        .count      (tx_count),
        .count_next (tx_count_next),
        .full       (tx_full),
        .empty      (tx_empty),
        .push_drop  (tx_drop)
    );

    // Read-source decode for the access presented this cycle.
    always_comb begin
        sel_next = SEL_RAM;
        if (is_io) begin
            if (io_off[15:2] == OFF_CNT[15:2]) begin
                case (io_off[1:0])
                    2'd0:    sel_next = SEL_CNT0;
                    2'd1:    sel_next = SEL_CNT1;
                    2'd2:    sel_next = SEL_CNT2;
                    default: sel_next = SEL_CNT3;
                endcase
            end else if (io_off == OFF_UART) begin
                sel_next = SEL_RX;
            end else if (io_off[15:1] == OFF_STAT[15:1]) begin
`ifdef MMIO_STAT_EN
                sel_next = io_off[0] ? SEL_STAT1 : SEL_STAT0;
`else
                sel_next = SEL_ZERO;
`endif
            end else begin
                sel_next = SEL_ZERO;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_reg      <= SEL_RAM;
            rd_valid_reg <= 1'b0;
            rx_byte_reg  <= '0;
            snap_reg     <= '0;
        end else begin
            rd_valid_reg <= rd_req;
            if (rd_req) begin
                sel_reg <= sel_next;
                if (sel_next == SEL_RX) begin
                    rx_byte_reg <= rx_valid ? rx_data : '0;
                end
                // Only byte 0 snapshots, so a 4-byte read sequence is coherent.
                if (sel_next == SEL_CNT0) begin
                    snap_reg <= cnt_reg;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_reg       <= '0;
            prog_stop_reg <= 1'b0;
            io_full_reg   <= 1'b0;
        end else begin
            cnt_reg     <= cnt_reg + WORD_W'(1);
            io_full_reg <= (int'(tx_count_next) >= FULL_LEVEL);
            if (stop_wr) begin
                prog_stop_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_snap_byte
            assign snap_bytes[gi] = snap_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

`ifdef MMIO_STAT_EN
    logic [15:0] stat_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_reg <= '0;
        end else if (tx_drop && (stat_reg != 16'hFFFF)) begin
            stat_reg <= stat_reg + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = tx_drop;
`endif

    // rd_valid_reg gates the mux so writes, idle-after-reset and reset itself return 0.
    always_comb begin
        cpu_mem_din = '0;
        if (rd_valid_reg) begin
            case (sel_reg)
                SEL_RAM:   cpu_mem_din = ram_rdata;
                SEL_RX:    cpu_mem_din = rx_byte_reg;
                SEL_CNT0:  cpu_mem_din = snap_bytes[0];
                SEL_CNT1:  cpu_mem_din = snap_bytes[1];
                SEL_CNT2:  cpu_mem_din = snap_bytes[2];
                SEL_CNT3:  cpu_mem_din = snap_bytes[3];
`ifdef MMIO_STAT_EN
                SEL_STAT0: cpu_mem_din = stat_reg[7:0];
                SEL_STAT1: cpu_mem_din = stat_reg[15:8];
`endif
                default:   cpu_mem_din = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: expected read bytes and TX bytes are queued
// when stimulus is driven and compared when the bridge produces them.
module tb_mmio_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] cpu_mem_a = '0;
    logic        cpu_mem_wr = 1'b0;
    logic [7:0]  cpu_mem_dout = '0;
    logic [7:0]  cpu_mem_din;
    logic        io_buffer_full;
    logic        ram_we;
    logic [16:0] ram_a;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ack;
    logic        prog_stop;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    rd_exp_t    mon_e;
    logic [7:0] tx_q[$];
    logic [7:0] tx_exp;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic       rd_issue = 1'b0;
    logic       chk_pend = 1'b0;

    mmio_bridge dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_mem_a      (cpu_mem_a),
        .cpu_mem_wr     (cpu_mem_wr),
        .cpu_mem_dout   (cpu_mem_dout),
        .cpu_mem_din    (cpu_mem_din),
        .io_buffer_full (io_buffer_full),
        .ram_we         (ram_we),
        .ram_a          (ram_a),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ack         (rx_ack),
        .prog_stop      (prog_stop)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end else begin
            $display("[TB] ok %s: 0x%02h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic go_idle();
        cpu_mem_a    = '0;
        cpu_mem_wr   = 1'b0;
        cpu_mem_dout = '0;
        rd_issue     = 1'b0;
    endtask

    task automatic rd_start(input logic [31:0] a, input logic [7:0] exp, input string tag);
        rd_exp_t e;
        cpu_mem_a  = a;
        cpu_mem_wr = 1'b0;
        rd_issue   = 1'b1;
        e.tag = tag;
        e.val = exp;
        rd_q.push_back(e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_mem_a    = a;
        cpu_mem_wr   = 1'b1;
        cpu_mem_dout = d;
        rd_issue     = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && tx_valid; i++) tick();
        tx_ready = 1'b0;
        check(tag, 8'(tx_valid), 8'h00);
        check({tag, "_sb_left"}, 8'(tx_q.size()), 8'h00);
    endtask

    // Read data scoreboard: one-cycle latency after the read was issued.
    always @(posedge clk_in) chk_pend <= rd_issue;

    always @(negedge clk_in) begin
        if (chk_pend) begin
            if (rd_q.size() == 0) begin
                check("rd_sb_underflow", cpu_mem_din, ~cpu_mem_din);
            end else begin
                mon_e = rd_q.pop_front();
                check(mon_e.tag, cpu_mem_din, mon_e.val);
            end
        end
        if (!rst_in && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                check("tx_sb_underflow", tx_data, ~tx_data);
            end else begin
                tx_exp = tx_q.pop_front();
                check("tx_byte", tx_data, tx_exp);
            end
        end
    end

    initial begin
        // Reset state, then counter snapshot after 300 idle cycles.
        rst_in = 1'b1;
        repeat (3) tick();
        check("rst_din", cpu_mem_din, 8'h00);
        check("rst_ibf", 8'(io_buffer_full), 8'h00);
        check("rst_ram_we", 8'(ram_we), 8'h00);
        check("rst_tx_valid", 8'(tx_valid), 8'h00);
        check("rst_rx_ack", 8'(rx_ack), 8'h00);
        check("rst_prog_stop", 8'(prog_stop), 8'h00);
        rst_in = 1'b0;
        repeat (300) tick();
        rd_start(32'h0003_0004, 8'h2C, "cnt_b0");
        tick();
        rd_start(32'h0003_0005, 8'h01, "cnt_b1");
        tick();
        rd_start(32'h0003_0006, 8'h00, "cnt_b2");
        tick();
        go_idle();
        tick();

        // RAM read and write.
        rd_start(32'h0000_0123, 8'h5A, "ram_rd");
        ram_rdata = 8'h00;
        #1;
        check("ram_a_lo", ram_a[7:0], 8'h23);
        check("ram_a_hi", 8'(ram_a[16:8]), 8'h01);
        check("ram_we_rd", 8'(ram_we), 8'h00);
        tick();
        ram_rdata = 8'h5A;
        go_idle();
        tick();
        ram_rdata = 8'h00;
        cpu_mem_a = 32'h0000_0456;
        cpu_mem_wr = 1'b1;
        cpu_mem_dout = 8'h77;
        #1;
        check("ram_we_wr", 8'(ram_we), 8'h01);
        check("ram_wdata", ram_wdata, 8'h77);
        cpu_mem_a = 32'h0003_0010;
        #1;
        check("ram_we_io", 8'(ram_we), 8'h00);
        tick();
        go_idle();
        rd_start(32'h0003_0010, 8'h00, "io_unmapped");
        ram_rdata = 8'hEE;
        tick();
        go_idle();
        tick();
        ram_rdata = 8'h00;

        // RX path with and without a byte present.
        rx_valid = 1'b1;
        rx_data  = 8'h37;
        rd_start(32'h0003_0000, 8'h37, "rx_rd");
        #1;
        check("rx_ack_hi", 8'(rx_ack), 8'h01);
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h99;
        rd_start(32'h0003_0000, 8'h00, "rx_empty");
        #1;
        check("rx_ack_lo", 8'(rx_ack), 8'h00);
        tick();
        go_idle();
        tick();

        // TX: zero byte ignored, order preserved.
        wr(32'h0003_0000, 8'h41);
        tx_q.push_back(8'h41);
        wr(32'h0003_0000, 8'h00);
        wr(32'h0003_0000, 8'h42);
        tx_q.push_back(8'h42);
        go_idle();
        tick();
        check("tx_head", tx_data, 8'h41);
        drain("tx_drain");

        // Near-full threshold, overflow drop, push+pop while full.
        for (int i = 0; i < 9; i++) begin
            wr(32'h0003_0000, 8'(8'h11 + i));
            if (i < 8) tx_q.push_back(8'(8'h11 + i));
            if (i == 4) check("ibf_after5", 8'(io_buffer_full), 8'h00);
            if (i == 5) check("ibf_after6", 8'(io_buffer_full), 8'h01);
        end
        tx_ready = 1'b1;
        wr(32'h0003_0000, 8'h99);
        tx_q.push_back(8'h99);
        tx_ready = 1'b0;
        check("ibf_pushpop_full", 8'(io_buffer_full), 8'h01);
`ifdef MMIO_STAT_EN
        rd_start(32'h0003_0008, 8'h01, "stat_lo");
`else
        rd_start(32'h0003_0008, 8'h00, "stat_lo");
`endif
        tick();
        rd_start(32'h0003_0009, 8'h00, "stat_hi");
        tick();
        go_idle();
        tick();
        drain("full_drain");
        check("ibf_drained", 8'(io_buffer_full), 8'h00);

        // Program stop, then reset mid-operation.
        wr(32'h0003_0004, 8'h00);
        tx_q.push_back(8'h00);
        go_idle();
        check("prog_stop_set", 8'(prog_stop), 8'h01);
        check("stop_tx_valid", 8'(tx_valid), 8'h01);
        check("stop_tx_zero", tx_data, 8'h00);
        for (int i = 0; i < 6; i++) begin
            wr(32'h0003_0000, 8'(8'hA0 + i));
        end
        go_idle();
        check("ibf_before_rst", 8'(io_buffer_full), 8'h01);
        rst_in    = 1'b1;
        cpu_mem_a = 32'h0003_0000;
        rx_valid  = 1'b1;
        rx_data   = 8'h55;
        #1;
        check("rx_ack_in_rst", 8'(rx_ack), 8'h00);
        tick();
        tx_q.delete();
        check("rst2_prog_stop", 8'(prog_stop), 8'h00);
        check("rst2_tx_valid", 8'(tx_valid), 8'h00);
        check("rst2_ibf", 8'(io_buffer_full), 8'h00);
        check("rst2_inflight", cpu_mem_din, 8'h00);
        rst_in   = 1'b0;
        rx_valid = 1'b0;
        go_idle();
        tick();
        tick();
        check("rd_sb_left", 8'(rd_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
